// File: rtl/sw_alloc_2to1_pkg.sv
// Shared flit-format definitions and helpers for the 2:1 switch allocator.
package sw_alloc_2to1_pkg;

    localparam int DATAW_P1 = 34;
    localparam int PORT_P1  = 2;
    localparam int TYPE_LSB = 32;
    localparam int TYPE_W   = 2;

    typedef enum logic [TYPE_W-1:0] {
        TYPE_NONE = 2'd0,
        TYPE_HEAD = 2'd1,
        TYPE_DATA = 2'd2,
        TYPE_TAIL = 2'd3
    } flit_type_e;

    // A valid flit that cannot start a packet
    function automatic logic is_stray(input logic valid, input flit_type_e ftype);
        return valid && (ftype != TYPE_HEAD) && (ftype != TYPE_NONE);
    endfunction

endpackage

// File: rtl/sw_alloc_2to1_if.sv
// Input-port, downstream-ready and grant/select signals of one router output port.
interface sw_alloc_2to1_if;
    import sw_alloc_2to1_pkg::*;

    logic [DATAW_P1-1:0] idata_0;
    logic                ivalid_0;
    logic [DATAW_P1-1:0] idata_1;
    logic                ivalid_1;
    logic                oready;
    logic [PORT_P1-1:0]  sel;
    logic                grant_0;
    logic                grant_1;
    logic                err_timeout;
    logic                err_proto;

    modport master (
        output idata_0, ivalid_0, idata_1, ivalid_1, oready,
        input  sel, grant_0, grant_1, err_timeout, err_proto
    );

    modport slave (
        input  idata_0, ivalid_0, idata_1, ivalid_1, oready,
        output sel, grant_0, grant_1, err_timeout, err_proto
    );

endinterface

// File: rtl/sw_alloc_2to1_rr_pick2.sv
// Combinational 2-way round-robin pick: on a tie the port that was not served last wins.
module rr_pick2 (
    input  logic [1:0] cand,
    input  logic       last,
    output logic       win,
    output logic       any
);

    assign any = |cand;
    assign win = (&cand) ? ~last : cand[1];

endmodule

// File: rtl/sw_alloc_2to1.sv
// Packet-level switch allocator for a 2:1 output mux: locks one packet head-to-tail,
// round-robin between packets, stalls on backpressure, watchdog on starved locks.
module sw_alloc_2to1
    import sw_alloc_2to1_pkg::*;
#(
    parameter int TIMEOUT = 64,
    parameter int CNTW    = 7
) (
    input logic             clk,
    input logic             rst_,
    sw_alloc_2to1_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOCK0 = 2'd1,
        LOCK1 = 2'd2
    } state_e;

    localparam logic [CNTW-1:0] CNT_MAX = CNTW'(TIMEOUT);

    state_e             state_q, state_d;
    logic               last_q, last_d;
    logic [CNTW-1:0]    cnt_q, cnt_d;
    logic               err_to_q;
    logic [PORT_P1-1:0] sel_q;

    flit_type_e type_0, type_1, ltype;
    logic [1:0] cand;
    logic       win, any;
    logic       lock_port, lvalid, xfer;
    logic       g0, g1, proto;
    logic       unused_payload;

    assign type_0 = flit_type_e'(bus.idata_0[TYPE_LSB +: TYPE_W]);
    assign type_1 = flit_type_e'(bus.idata_1[TYPE_LSB +: TYPE_W]);
    assign unused_payload = ^{bus.idata_0[TYPE_LSB-1:0], bus.idata_1[TYPE_LSB-1:0]};

    assign cand = {bus.ivalid_1 && (type_1 == TYPE_HEAD),
                   bus.ivalid_0 && (type_0 == TYPE_HEAD)};

    rr_pick2 u_pick (
        .cand (cand),
        .last (last_q),
        .win  (win),
        .any  (any)
    );

    assign lock_port = (state_q == LOCK1);
    assign lvalid    = lock_port ? bus.ivalid_1 : bus.ivalid_0;
    assign ltype     = lock_port ? type_1 : type_0;

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        xfer    = 1'b0;
        g0      = 1'b0;
        g1      = 1'b0;
        proto   = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                proto = is_stray(bus.ivalid_0, type_0) || is_stray(bus.ivalid_1, type_1);
                if (any) state_d = win ? LOCK1 : LOCK0;
            end
            LOCK0, LOCK1: begin
                xfer = lvalid && bus.oready;
                g0   = xfer && !lock_port;
                g1   = xfer && lock_port;
                if (xfer) begin
                    cnt_d = '0;
                    if (ltype == TYPE_TAIL) begin
                        state_d = IDLE;
                        last_d  = lock_port;
                    end
                end else if (!lvalid && (cnt_q != CNT_MAX)) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // sel is decoded from the next state so it lines up with the registered state
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state_q  <= IDLE;
            last_q   <= 1'b1;
            cnt_q    <= '0;
            err_to_q <= 1'b0;
            sel_q    <= '0;
        end else begin
            state_q  <= state_d;
            last_q   <= last_d;
            cnt_q    <= cnt_d;
            err_to_q <= err_to_q | (cnt_d == CNT_MAX);
            sel_q    <= {state_d == LOCK1, state_d == LOCK0};
        end
    end

    assign bus.sel         = sel_q;
    assign bus.grant_0     = g0;
    assign bus.grant_1     = g1;
    assign bus.err_timeout = err_to_q;
    assign bus.err_proto   = proto;

endmodule

// File: tb/tb_sw_alloc_2to1.sv
// Self-checking bench for sw_alloc_2to1: directed table, corner sequences, random traffic vs. a packet-level model.
module tb_sw_alloc_2to1;
    import sw_alloc_2to1_pkg::*;

    localparam int TIMEOUT = 64;

    logic clk = 1'b0;
    logic rst_;
    always #5 clk = ~clk;

    sw_alloc_2to1_if bus();

    sw_alloc_2to1 #(.TIMEOUT(TIMEOUT), .CNTW(7)) dut (
        .clk  (clk),
        .rst_ (rst_),
        .bus  (bus)
    );

    int vectors     = 0;
    int miscompares = 0;

    // Packet-level model: which port owns the output (-1 none), who was served last,
    // how long the owner has been starved, and the sticky timeout flag.
    int m_owner, m_last, m_starve;
    bit m_err;

    flit_type_e q0[$], q1[$];
    int dut_g0_count, dut_g1_count;
    int tail_owner[$];

    typedef struct {
        bit         v0;
        flit_type_e t0;
        bit         v1;
        flit_type_e t1;
        bit         rdy;
        logic [1:0] sel;
        bit         g0;
        bit         g1;
        bit         proto;
    } vec_t;

    vec_t tbl[14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_owner  = -1;
        m_last   = 1;
        m_starve = 0;
        m_err    = 1'b0;
        q0.delete();
        q1.delete();
    endtask

    function automatic logic [DATAW_P1-1:0] mkflit(input flit_type_e t);
        logic [63:0]         r;
        logic [DATAW_P1-1:0] f;
        r = {$urandom(), $urandom()};
        f = r[DATAW_P1-1:0];
        f[TYPE_LSB +: TYPE_W] = t;
        return f;
    endfunction

    task automatic step(input bit v0, input flit_type_e t0, input bit v1, input flit_type_e t1,
                        input bit rdy, output bit g0, output bit g1, output bit was_idle);
        bit         vv[2];
        flit_type_e tt[2];
        bit         gg[2];
        bit         proto, head0, head1;
        logic [1:0] esel;
        @(negedge clk);
        bus.ivalid_0 = v0;
        bus.idata_0  = mkflit(t0);
        bus.ivalid_1 = v1;
        bus.idata_1  = mkflit(t1);
        bus.oready   = rdy;
        #2;
        vv = '{v0, v1};
        tt = '{t0, t1};
        esel  = (m_owner < 0) ? 2'b00 : ((m_owner == 0) ? 2'b01 : 2'b10);
        gg[0] = (m_owner == 0) && v0 && rdy;
        gg[1] = (m_owner == 1) && v1 && rdy;
        proto = (m_owner < 0) &&
                ((v0 && t0 != TYPE_HEAD && t0 != TYPE_NONE) ||
                 (v1 && t1 != TYPE_HEAD && t1 != TYPE_NONE));
        chk("sel", 32'(bus.sel), 32'(esel));
        chk("grant_0", 32'(bus.grant_0), 32'(gg[0]));
        chk("grant_1", 32'(bus.grant_1), 32'(gg[1]));
        chk("err_proto", 32'(bus.err_proto), 32'(proto));
        chk("err_timeout", 32'(bus.err_timeout), 32'(m_err));
        if (bus.grant_0 === 1'b1) dut_g0_count++;
        if (bus.grant_1 === 1'b1) dut_g1_count++;
        if (bus.grant_0 === 1'b1 && t0 == TYPE_TAIL) tail_owner.push_back(0);
        if (bus.grant_1 === 1'b1 && t1 == TYPE_TAIL) tail_owner.push_back(1);
        was_idle = (m_owner < 0);
        g0 = gg[0];
        g1 = gg[1];
        head0 = v0 && t0 == TYPE_HEAD;
        head1 = v1 && t1 == TYPE_HEAD;
        if (m_owner < 0) begin
            m_starve = 0;
            if (head0 && head1) m_owner = 1 - m_last;
            else if (head0)     m_owner = 0;
            else if (head1)     m_owner = 1;
        end else if (gg[m_owner]) begin
            m_starve = 0;
            if (tt[m_owner] == TYPE_TAIL) begin
                m_last  = m_owner;
                m_owner = -1;
            end
        end else if (!vv[m_owner]) begin
            if (m_starve < TIMEOUT) m_starve++;
        end
        if (m_starve == TIMEOUT) m_err = 1'b1;
    endtask

    // Sources present their queue fronts; a stray non-head front is flushed once seen while idle.
    task automatic run(input int n, input int gap_pct, input int rdy_pct);
        for (int i = 0; i < n; i++) begin
            bit v0, v1, r, g0, g1, idle;
            flit_type_e t0, t1;
            v0 = (q0.size() > 0) && ($urandom_range(99) >= gap_pct);
            v1 = (q1.size() > 0) && ($urandom_range(99) >= gap_pct);
            t0 = (q0.size() > 0) ? q0[0] : TYPE_NONE;
            t1 = (q1.size() > 0) ? q1[0] : TYPE_NONE;
            r  = ($urandom_range(99) < rdy_pct);
            step(v0, t0, v1, t1, r, g0, g1, idle);
            if (g0 || (idle && v0 && t0 != TYPE_HEAD)) void'(q0.pop_front());
            if (g1 || (idle && v1 && t1 != TYPE_HEAD)) void'(q1.pop_front());
        end
    endtask

    task automatic drain(input int limit, input int gap_pct, input int rdy_pct);
        int i = 0;
        while ((q0.size() > 0 || q1.size() > 0 || m_owner >= 0) && i < limit) begin
            run(1, gap_pct, rdy_pct);
            i++;
        end
        chk("drain_bound", 32'(q0.size() + q1.size() + ((m_owner >= 0) ? 1 : 0)), 32'd0);
    endtask

    task automatic push_pkt(input int port, input int ndata);
        if (port == 0) q0.push_back(TYPE_HEAD); else q1.push_back(TYPE_HEAD);
        for (int k = 0; k < ndata; k++)
            if (port == 0) q0.push_back(TYPE_DATA); else q1.push_back(TYPE_DATA);
        if (port == 0) q0.push_back(TYPE_TAIL); else q1.push_back(TYPE_TAIL);
    endtask

    // Asynchronous reset landing between clock edges, with whatever inputs are active
    task automatic do_reset();
        @(negedge clk);
        #3;
        rst_ = 1'b0;
        #1;
        chk("rst_sel", 32'(bus.sel), 32'd0);
        chk("rst_grant_0", 32'(bus.grant_0), 32'd0);
        chk("rst_grant_1", 32'(bus.grant_1), 32'd0);
        chk("rst_err_timeout", 32'(bus.err_timeout), 32'd0);
        bus.ivalid_0 = 1'b0;
        bus.ivalid_1 = 1'b0;
        model_reset();
        @(negedge clk);
        rst_ = 1'b1;
    endtask

    initial begin
        bit g0, g1, idle;

        tbl[0]  = '{1'b1, TYPE_DATA, 1'b0, TYPE_NONE, 1'b1, 2'b00, 1'b0, 1'b0, 1'b1};
        tbl[1]  = '{1'b0, TYPE_NONE, 1'b1, TYPE_TAIL, 1'b1, 2'b00, 1'b0, 1'b0, 1'b1};
        tbl[2]  = '{1'b1, TYPE_HEAD, 1'b1, TYPE_HEAD, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0};
        tbl[3]  = '{1'b1, TYPE_DATA, 1'b1, TYPE_HEAD, 1'b1, 2'b01, 1'b1, 1'b0, 1'b0};
        tbl[4]  = '{1'b1, TYPE_TAIL, 1'b1, TYPE_HEAD, 1'b0, 2'b01, 1'b0, 1'b0, 1'b0};
        tbl[5]  = '{1'b1, TYPE_TAIL, 1'b1, TYPE_HEAD, 1'b1, 2'b01, 1'b1, 1'b0, 1'b0};
        tbl[6]  = '{1'b0, TYPE_NONE, 1'b1, TYPE_HEAD, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0};
        tbl[7]  = '{1'b0, TYPE_NONE, 1'b1, TYPE_DATA, 1'b1, 2'b10, 1'b0, 1'b1, 1'b0};
        tbl[8]  = '{1'b1, TYPE_DATA, 1'b1, TYPE_TAIL, 1'b1, 2'b10, 1'b0, 1'b1, 1'b0};
        tbl[9]  = '{1'b1, TYPE_HEAD, 1'b1, TYPE_HEAD, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0};
        tbl[10] = '{1'b1, TYPE_TAIL, 1'b1, TYPE_HEAD, 1'b1, 2'b01, 1'b1, 1'b0, 1'b0};
        tbl[11] = '{1'b1, TYPE_HEAD, 1'b1, TYPE_HEAD, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0};
        tbl[12] = '{1'b1, TYPE_HEAD, 1'b1, TYPE_TAIL, 1'b1, 2'b10, 1'b0, 1'b1, 1'b0};
        tbl[13] = '{1'b0, TYPE_NONE, 1'b0, TYPE_NONE, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0};

        rst_ = 1'b0;
        bus.ivalid_0 = 1'b0;
        bus.ivalid_1 = 1'b0;
        bus.idata_0  = '0;
        bus.idata_1  = '0;
        bus.oready   = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        chk("reset_sel", 32'(bus.sel), 32'd0);
        chk("reset_err_timeout", 32'(bus.err_timeout), 32'd0);
        chk("reset_err_proto", 32'(bus.err_proto), 32'd0);
        rst_ = 1'b1;

        // Directed table: strays while idle, tie-breaks, backpressure, ignored off-port flits
        for (int i = 0; i < 14; i++) begin
            step(tbl[i].v0, tbl[i].t0, tbl[i].v1, tbl[i].t1, tbl[i].rdy, g0, g1, idle);
            chk("tbl_sel", 32'(bus.sel), 32'(tbl[i].sel));
            chk("tbl_grant_0", 32'(bus.grant_0), 32'(tbl[i].g0));
            chk("tbl_grant_1", 32'(bus.grant_1), 32'(tbl[i].g1));
            chk("tbl_err_proto", 32'(bus.err_proto), 32'(tbl[i].proto));
        end

        // Long single packet on port1
        push_pkt(1, 20);
        dut_g1_count = 0;
        drain(100, 0, 100);
        chk("long_pkt_grant_1_count", 32'(dut_g1_count), 32'd22);

        // Simultaneous heads after reset, then back-to-back packets on both ports
        do_reset();
        for (int k = 0; k < 4; k++) begin
            push_pkt(0, k + 1);
            push_pkt(1, 3 - k);
        end
        tail_owner.delete();
        drain(400, 0, 100);
        chk("rr_packet_count", 32'(tail_owner.size()), 32'd8);
        for (int i = 0; i < tail_owner.size() && i < 8; i++)
            chk("rr_order", 32'(tail_owner[i]), 32'(i % 2));

        // Five stalled cycles mid-packet
        push_pkt(0, 6);
        dut_g0_count = 0;
        run(3, 0, 100);
        run(5, 0, 0);
        drain(100, 0, 100);
        chk("stall_pkt_grant_0_count", 32'(dut_g0_count), 32'd8);

        // Watchdog: locked port0 starves for exactly TIMEOUT cycles
        q0.push_back(TYPE_HEAD);
        q0.push_back(TYPE_DATA);
        run(3, 0, 100);
        run(TIMEOUT - 1, 0, 100);
        chk("timeout_not_yet", 32'(m_err), 32'd0);
        run(1, 0, 100);
        #4;
        chk("timeout_set", 32'(bus.err_timeout), 32'd1);
        q0.push_back(TYPE_TAIL);
        drain(20, 0, 100);
        run(3, 0, 100);
        #4;
        chk("timeout_sticky", 32'(bus.err_timeout), 32'd1);

        // Random traffic with gaps, backpressure and stray flits
        do_reset();
        for (int r = 0; r < 40; r++) begin
            int port;
            port = int'($urandom_range(1));
            if ($urandom_range(9) == 0 && ((port == 0) ? q0.size() : q1.size()) == 0) begin
                if (port == 0) q0.push_back(TYPE_DATA); else q1.push_back(TYPE_TAIL);
            end
            push_pkt(port, int'($urandom_range(5)));
            if ($urandom_range(1) == 1) push_pkt(1 - port, int'($urandom_range(5)));
            run(15, 20, 75);
        end
        drain(3000, 10, 80);

        // Reset in the middle of a packet
        push_pkt(0, 10);
        run(4, 0, 100);
        do_reset();
        run(3, 0, 100);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
